div_seq: RTL and testbench

- Iterative radix-2 divide sequencer for the 5-stage MIPS pipeline.
- Accepts DIV/DIVU issued in Execute and produces quotient (LO) and remainder (HI).
- Holds a stall request to the hazard unit until the result is ready.
- Sits beside the Execute-stage ALU. Its stall output is ORed into the pipeline stall/flush logic.

---
 rtl/div_seq.sv | 124 ++++++++++++
 tb/tb_div_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU in Execute; stalls the pipeline until hi/lo are ready.
// Optional macro DIV_SEQ_EARLY_ZERO_EN: a zero divisor skips the iteration and goes straight to DONE.
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             startE,
   input  logic             signedE,
   input  logic [WIDTH-1:0] srcaE,
   input  logic [WIDTH-1:0] srcbE,
   input  logic             cancel,
   output logic             stallE,
   output logic             result_valid,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             div_zero
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nx;

   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem, quo, dvs, dvd;
   logic [WIDTH-1:0] lo_q, hi_q, lo_fix, hi_fix;
   logic             neg_q, neg_r, zero, dz_q, stall;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH:0]   rem_sh, diff;

   assign mag_a = (signedE && srcaE[WIDTH-1]) ? -srcaE : srcaE;
   assign mag_b = (signedE && srcbE[WIDTH-1]) ? -srcbE : srcbE;

   // one extra bit so the trial subtraction exposes its borrow
   assign rem_sh = {rem, quo[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, dvs};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      stall        = 1'b0;
      result_valid = 1'b0;
      case (state)
         IDLE: if (startE) begin
            stall = 1'b1;
`ifdef DIV_SEQ_EARLY_ZERO_EN
            state_nx = (srcbE == '0) ? DONE : BUSY;
`else
            state_nx = BUSY;
`endif
         end
         BUSY: begin
            stall = 1'b1;
            if (count == CW'(1)) state_nx = DONE;
         end
         DONE: begin
            result_valid = 1'b1;
            state_nx     = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (cancel) begin
         state_nx     = IDLE;
         stall        = 1'b0;
         result_valid = 1'b0;
      end
   end

   // gated by reset so a held startE cannot raise a stall while the block is held in reset
   assign stallE = stall & rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         dvd   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         zero  <= 1'b0;
         lo_q  <= '0;
         hi_q  <= '0;
         dz_q  <= 1'b0;
      end else begin
         if (state == IDLE && startE && !cancel) begin
            count <= CW'(WIDTH);
            rem   <= '0;
            quo   <= mag_a;
            dvs   <= mag_b;
            dvd   <= srcaE;
            neg_q <= signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
            neg_r <= signedE & srcaE[WIDTH-1];
            zero  <= (srcbE == '0);
         end else if (state == BUSY && !cancel) begin
            count <= count - CW'(1);
            if (!diff[WIDTH]) begin
               rem <= diff[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
               rem <= rem_sh[WIDTH-1:0];
               quo <= {quo[WIDTH-2:0], 1'b0};
            end
         end
         if (result_valid) begin
            lo_q <= lo_fix;
            hi_q <= hi_fix;
            dz_q <= zero;
         end
      end
   end

   // MIN / -1 wraps naturally: |MIN| = MIN and its negation is MIN again
   assign lo_fix = zero ? '1  : (neg_q ? -quo : quo);
   assign hi_fix = zero ? dvd : (neg_r ? -rem : rem);

   assign lo       = (state == DONE) ? lo_fix : lo_q;
   assign hi       = (state == DONE) ? hi_fix : hi_q;
   assign div_zero = (state == DONE) ? zero   : dz_q;
endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: scoreboard of expected hi/lo/div_zero plus stall-length and pulse-spacing checks.
module tb_div_seq;
   localparam int W = 32;
`ifdef DIV_SEQ_EARLY_ZERO_EN
   localparam int ZSTALL = 1;
`else
   localparam int ZSTALL = W + 1;
`endif

   logic         clk = 0, rst_n = 0, startE = 0, signedE = 0, cancel = 0;
   logic [W-1:0] srcaE = '0, srcbE = '0;
   logic         stallE, result_valid, div_zero;
   logic [W-1:0] lo, hi;

   div_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .startE(startE), .signedE(signedE),
      .srcaE(srcaE), .srcbE(srcbE), .cancel(cancel), .stallE(stallE),
      .result_valid(result_valid), .lo(lo), .hi(hi), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0, pulse_cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         dz;
   } exp_t;
   exp_t sb[$];
   logic [W-1:0] last_lo = '0, last_hi = '0;

   function automatic exp_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      logic [W-1:0] minv;
      minv = {1'b1, {(W-1){1'b0}}};
      e.dz = (b == '0);
      if (b == '0) begin
         e.lo = '1; e.hi = a;
      end else if (s) begin
         if (a == minv && b == '1) begin
            e.lo = minv; e.hi = '0;
         end else begin
            e.lo = $signed(a) / $signed(b);
            e.hi = $signed(a) % $signed(b);
         end
      end else begin
         e.lo = a / b; e.hi = a % b;
      end
      return e;
   endfunction

   task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      @(posedge clk); #1;
      signedE = s; srcaE = a; srcbE = b; startE = 1;
      sb.push_back(model(s, a, b));
   endtask

   task automatic end_op();
      @(posedge clk); #1;
      startE = 0;
   endtask

   task automatic wait_result(input string name, input int exp_stall,
                              input logic [W-1:0] xlo, input logic [W-1:0] xhi, input logic xdz);
      int   st = 0;
      bit   got = 0;
      exp_t e;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (result_valid) got = 1;
         else if (stallE) st++;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL %s timeout: no result_valid within 200 cycles", name);
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      pulse_cyc = cyc;
      e = sb.pop_front();
      checks += 6;
      if (lo !== e.lo) begin errors++; $display("FAIL %s lo got %h exp %h", name, lo, e.lo); end
      if (hi !== e.hi) begin errors++; $display("FAIL %s hi got %h exp %h", name, hi, e.hi); end
      if (div_zero !== e.dz) begin errors++; $display("FAIL %s div_zero got %b exp %b", name, div_zero, e.dz); end
      if (st !== exp_stall) begin errors++; $display("FAIL %s stall_cycles got %0d exp %0d", name, st, exp_stall); end
      if (stallE !== 1'b0) begin errors++; $display("FAIL %s stallE_in_done got %b exp 0", name, stallE); end
      if ({lo, hi, div_zero} !== {xlo, xhi, xdz}) begin
         errors++;
         $display("FAIL %s table lo/hi/dz got %h/%h/%b exp %h/%h/%b", name, lo, hi, div_zero, xlo, xhi, xdz);
      end
      last_lo = e.lo; last_hi = e.hi;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({stallE, result_valid, lo, hi, div_zero} !== '0) begin
         errors++;
         $display("FAIL reset outputs got stall=%b rv=%b lo=%h hi=%h dz=%b exp all 0", stallE, result_valid, lo, hi, div_zero);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic test_unsigned();
      start_op(0, 100, 7);
      wait_result("divu_100_7", W + 1, 14, 2, 0);
      end_op();
      @(negedge clk);
      checks++;
      if (lo !== last_lo || hi !== last_hi || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL hold_after_done got lo=%h hi=%h rv=%b exp lo=%h hi=%h rv=0", lo, hi, result_valid, last_lo, last_hi);
      end
   endtask

   task automatic test_signed();
      start_op(1, 32'hFFFF_FFF9, 32'h2);
      wait_result("div_m7_2", W + 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
      end_op();
      start_op(1, 32'h7, 32'hFFFF_FFFE);
      wait_result("div_7_m2", W + 1, 32'hFFFF_FFFD, 32'h1, 0);
      end_op();
      start_op(1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_result("div_min_m1", W + 1, 32'h8000_0000, 32'h0, 0);
      end_op();
   endtask

   task automatic test_div_zero();
      start_op(0, 32'h1234_5678, 32'h0);
      wait_result("divu_by_zero", ZSTALL, 32'hFFFF_FFFF, 32'h1234_5678, 1);
      end_op();
      start_op(1, 32'h8765_4321, 32'h0);
      wait_result("div_neg_by_zero", ZSTALL, 32'hFFFF_FFFF, 32'h8765_4321, 1);
      end_op();
   endtask

   task automatic test_back_to_back();
      int first;
      start_op(0, 50, 5);
      wait_result("b2b_first", W + 1, 10, 0, 0);
      first = pulse_cyc;
      start_op(0, 9, 4);
      wait_result("b2b_second", W + 1, 2, 1, 0);
      end_op();
      checks++;
      if (pulse_cyc - first !== 34) begin
         errors++;
         $display("FAIL b2b_spacing got %0d exp 34", pulse_cyc - first);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         logic         s;
         logic [W-1:0] a, b;
         exp_t         e;
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         b = (i == 3) ? '0 : (W'($urandom) >> $urandom_range(0, 28));
         e = model(s, a, b);
         start_op(s, a, b);
         wait_result("random", (b == '0) ? ZSTALL : W + 1, e.lo, e.hi, e.dz);
         end_op();
      end
   endtask

   task automatic test_cancel();
      bit seen = 0;
      start_op(0, 1000, 3);
      void'(sb.pop_back());
      repeat (10) @(posedge clk);
      #1 cancel = 1; startE = 0;
      @(negedge clk);
      checks++;
      if (stallE !== 1'b0 || result_valid !== 1'b0) begin
         errors++;
         $display("FAIL cancel_cycle got stall=%b rv=%b exp 0/0", stallE, result_valid);
      end
      @(posedge clk); #1 cancel = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (result_valid || stallE) seen = 1;
      end
      checks += 2;
      if (seen) begin errors++; $display("FAIL cancel_quiet got activity exp none"); end
      if (lo !== last_lo || hi !== last_hi) begin
         errors++;
         $display("FAIL cancel_hold got lo=%h hi=%h exp lo=%h hi=%h", lo, hi, last_lo, last_hi);
      end
   endtask

   task automatic test_reset_mid();
      bit seen = 0;
      start_op(0, 500, 7);
      void'(sb.pop_back());
      repeat (5) @(posedge clk);
      #1 rst_n = 0;
      #1;
      checks++;
      if ({stallE, result_valid, lo, hi, div_zero} !== '0) begin
         errors++;
         $display("FAIL reset_mid got stall=%b rv=%b lo=%h hi=%h dz=%b exp all 0", stallE, result_valid, lo, hi, div_zero);
      end
      startE = 0;
      @(posedge clk); #1 rst_n = 1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (result_valid) seen = 1;
      end
      checks++;
      if (seen) begin errors++; $display("FAIL reset_mid_quiet got result_valid exp none"); end
      start_op(0, 1000, 3);
      wait_result("after_reset", W + 1, 333, 1, 0);
      end_op();
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_back_to_back();
      test_random();
      test_cancel();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
